// File: rtl/inst_issuer.sv
// Purpose: encodes register/immediate instructions and queues them for a downstream decoder.
// Latency: an accepted write is visible at the queue head one cycle later; there is no empty-queue bypass.
// Backpressure: inst_ready low holds the head; writes while full are dropped and flagged as overflow.

// Generic synchronous FIFO with a count output and a synchronous flush.
// Latency: pushed data reaches head_dat one cycle after the push edge.
// Backpressure: push is ignored when full and pop is ignored when empty; the caller gates both.
module issue_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count,
    output logic          full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Flush wins over both ports; push and pop are also guarded here so the
    // FIFO stays consistent even if a caller forgets to gate them.
    assign full     = (count == CW'(DEPTH));
    assign push_ok  = push && !full && !flush;
    assign pop_ok   = pop && (count != '0) && !flush;
    assign head_dat = mem[rd_ptr];

    // Storage has no reset: stale words are never visible because the
    // consumer qualifies head_dat with a non-zero count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks
    // occupancy so full and empty never need pointer comparison.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// Instruction encoder plus issue queue with sticky error flags and a handoff counter.
// Latency: one cycle from an accepted wr_en to the word appearing on inst_out.
// Backpressure: inst_valid/inst_ready handshake at the head; overflow writes dropped and flagged.
module inst_issuer #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       flush,
    input  logic       wr_en,
    input  logic [1:0] kind,
    input  logic [2:0] field_a,
    input  logic [2:0] field_b,
    input  logic [4:0] imm,
    output logic [7:0] inst_out,
    output logic       inst_valid,
    input  logic       inst_ready,
    output logic       full,
    output logic [4:0] count,
    output logic [1:0] err,
    input  logic       err_clr,
    output logic [7:0] issued
);
    typedef enum logic [1:0] {
        KIND_RR  = 2'b00,
        KIND_IX  = 2'b01,
        KIND_IY  = 2'b10,
        KIND_BAD = 2'b11
    } kind_e;

    typedef struct packed {
        logic [1:0] op;
        logic [5:0] body;
    } inst_t;

    kind_e      kind_sel;
    inst_t      enc;
    logic [7:0] head_dat;
    logic       wr_accept;
    logic       handoff;
    logic       illegal_ev;
    logic       overflow_ev;
    logic [1:0] err_ev;

    assign kind_sel = kind_e'(kind);

    // Encode at write time so the queue only ever holds finished 8-bit words.
    always_comb begin
        enc = '0;
        unique case (kind_sel)
            KIND_RR:  enc = '{op: 2'b00, body: {field_a, field_b}};
            KIND_IX:  enc = '{op: 2'b01, body: {1'b0, imm}};
            KIND_IY:  enc = '{op: 2'b01, body: {1'b1, imm}};
            default:  enc = '0;
        endcase
    end

    // Overflow is judged on the pre-edge full flag, so a same-cycle handoff
    // does not rescue a write that arrived while the queue was full. Flush
    // suppresses both the write and any error it would otherwise raise.
    assign wr_accept   = wr_en && (kind_sel != KIND_BAD) && !full && !flush;
    assign handoff     = inst_valid && inst_ready && !flush;
    assign illegal_ev  = wr_en && (kind_sel == KIND_BAD) && !flush;
    assign overflow_ev = wr_en && full && !flush;
    assign err_ev      = {overflow_ev, illegal_ev};

    issue_fifo #(
        .W     (8),
        .DEPTH (DEPTH),
        .CW    (5)
    ) u_fifo (
        .clk      (clk),
        .clr      (clr),
        .flush    (flush),
        .push     (wr_accept),
        .push_dat (enc),
        .pop      (handoff),
        .head_dat (head_dat),
        .count    (count),
        .full     (full)
    );

    // Head is masked to zero when empty so unreset storage never leaks out.
    assign inst_valid = (count != 5'd0);
    assign inst_out   = inst_valid ? head_dat : 8'h00;

    // Sticky error flags; a fresh event in the clearing cycle survives the clear.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            err <= 2'b00;
        end else if (err_clr) begin
            err <= err_ev;
        end else begin
            err <= err | err_ev;
        end
    end

    // Free-running handoff counter, wrapping at 8 bits; flush leaves it alone.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            issued <= 8'h00;
        end else if (handoff) begin
            issued <= issued + 8'd1;
        end
    end

endmodule

// File: doc/inst_issuer.md
INST_ISSUER -- requirements
Module: inst_issuer

Interface
- REQ-001 Parameter DEPTH, default 8, SHALL set the instruction queue depth in entries (power of two, 2..16).
- REQ-002 clk, input, 1, SHALL be the clock; all state updates on the rising edge.
- REQ-003 clr, input, 1, SHALL be the reset: asynchronous, active-low.
- REQ-004 flush, input, 1, SHALL be a synchronous queue clear.
- REQ-005 wr_en, input, 1, SHALL request that one instruction be encoded and enqueued.
- REQ-006 kind, input, 2, SHALL select the encoding: 00 register transfer, 01 immediate type X, 10 immediate type Y, 11 illegal.
- REQ-007 field_a and field_b, input, 3 each, SHALL be the register operands for kind 00.
- REQ-008 imm, input, 5, SHALL be the immediate operand for kinds 01 and 10.
- REQ-009 inst_out, output, 8, SHALL be the encoded instruction at the queue head.
- REQ-010 inst_valid, output, 1, SHALL indicate that inst_out holds a pending instruction.
- REQ-011 inst_ready, input, 1, SHALL be the consumer (decoder side) accept signal.
- REQ-012 full, output, 1, SHALL indicate that count equals DEPTH.
- REQ-013 count, output, 5, SHALL be the number of queued entries.
- REQ-014 err, output, 2, SHALL be sticky flags: bit0 illegal kind, bit1 overflow.
- REQ-015 err_clr, input, 1, SHALL clear err synchronously.
- REQ-016 issued, output, 8, SHALL be the count of instructions handed off, wrapping 255 -> 0.

Function
- REQ-017 Encoding SHALL be: kind 00 -> {2'b00, field_a, field_b}; kind 01 -> {2'b01, 1'b0, imm}; kind 10 -> {2'b01, 1'b1, imm}.
- REQ-018 Encoding SHALL occur at write time; the queue SHALL store 8-bit encoded words.
- REQ-019 A write SHALL be accepted when wr_en=1, kind!=11, full=0 and flush=0.
- REQ-020 wr_en=1 with kind=11 SHALL be dropped and SHALL set err[0] on that edge.
- REQ-021 wr_en=1 with full=1 SHALL be dropped and SHALL set err[1], even if a handoff occurs in the same cycle.
- REQ-022 A handoff SHALL occur on an edge where inst_valid=1, inst_ready=1 and flush=0; it pops the head and increments issued.
- REQ-023 inst_valid SHALL equal (count != 0); inst_out SHALL be the head entry when valid, else 8'h00.
- REQ-024 Write-to-visible latency SHALL be one cycle; there SHALL be no bypass from wr_en to inst_out when the queue is empty.
- REQ-025 inst_out and inst_valid SHALL remain stable while inst_valid=1 and inst_ready=0.
- REQ-026 A simultaneous accepted write and handoff SHALL leave count unchanged.
- REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
- REQ-028 Entries SHALL be issued in write order (FIFO).
- REQ-029 flush=1 SHALL zero count and both pointers on the edge, overriding write and handoff in that cycle.
- REQ-030 flush SHALL NOT change err or issued, and SHALL NOT set err for a concurrent wr_en.
- REQ-031 err_clr=1 SHALL clear err; a new error event in the same cycle SHALL win (flag set).

Reset
- REQ-032 clr=0 SHALL immediately force: count=0, pointers=0, full=0, inst_valid=0, inst_out=8'h00, err=2'b00, issued=8'h00.
- REQ-033 clr asserted mid-stream SHALL discard all queued entries; the first write after release SHALL become the head.
- REQ-034 Queue storage contents need not be reset.

Verification
- REQ-035 Encode check: kind=00, a=3, b=5, inst_ready=0 -> next cycle inst_out=8'h1D, inst_valid=1, count=1.
- REQ-036 Immediate encodes: kind=01, imm=5'h0A -> 8'h4A; kind=10, imm=5'h0A -> 8'h6A; both issued in order with inst_ready=1, after which issued=2.
- REQ-037 Full/overflow: DEPTH=8, 9 writes with inst_ready=0 -> full=1, count=8, err=2'b10; drained order matches the first 8 writes.
- REQ-038 Illegal kind: kind=11 write -> count unchanged, err[0]=1; err_clr -> err=00.
- REQ-039 Stall and concurrency: inst_ready low for 3 cycles -> inst_out stable; with count=4, simultaneous write and handoff -> count=4.
- REQ-040 Flush and reset: flush with count=5 -> count=0, inst_valid=0, issued unchanged; clr pulse mid-stream -> all outputs at reset values asynchronously; 256 handoffs -> issued wraps to 0.
